// File: rtl/call_frame_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | call_frame_fetch_pkg                                                     |
// | Shared frame-word layout and fetch FSM encoding for the recursion engine.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package call_frame_fetch_pkg;

  localparam int FRAME_ADDR_W = 12;

  // State word: {position, parent address, over}
  localparam int STATE_W  = 18;
  localparam int POS_MSB  = 17;
  localparam int POS_LSB  = 13;
  localparam int PAR_MSB  = 12;
  localparam int PAR_LSB  = 1;
  localparam int OVER_BIT = 0;

  // InexRecur word: {i, z, k, l}
  localparam int INEX_W     = 32;
  localparam int INEX_I_MSB = 31;
  localparam int INEX_I_LSB = 24;
  localparam int INEX_Z_MSB = 23;
  localparam int INEX_Z_LSB = 16;
  localparam int INEX_K_MSB = 15;
  localparam int INEX_K_LSB = 8;
  localparam int INEX_L_MSB = 7;
  localparam int INEX_L_LSB = 0;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] C_ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] C_ST_READ    = 3'd1;
  localparam logic [ST_W-1:0] C_ST_LATCH   = 3'd2;
  localparam logic [ST_W-1:0] C_ST_PRESENT = 3'd3;
  localparam logic [ST_W-1:0] C_ST_WB_WAIT = 3'd4;
  localparam logic [ST_W-1:0] C_ST_DONE    = 3'd5;
  localparam logic [ST_W-1:0] C_ST_OVF     = 3'd6;

endpackage
`default_nettype wire

// File: rtl/call_frame_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | call_frame_fetch                                                         |
// | Fetches/pops call frames, presents live ones, owns the push pointer.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module call_frame_fetch
  import call_frame_fetch_pkg::*;
#(
  parameter int ADDR_W = FRAME_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [STATE_W-1:0] rd_state,
  input  logic [INEX_W-1:0]  rd_inex,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [4:0]         out_position,
  output logic [7:0]         out_i,
  output logic [7:0]         out_z,
  output logic [7:0]         out_k,
  output logic [7:0]         out_l,
  input  logic               wb_done,
  input  logic               wb_new_call,
  output logic [ADDR_W-1:0]  seq_w_addr,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  logic [ST_W-1:0]   r_state;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_seq_ptr;
  logic [4:0]        r_position;
  logic [7:0]        r_i;
  logic [7:0]        r_z;
  logic [7:0]        r_k;
  logic [7:0]        r_l;

  logic              w_over;
  logic [ADDR_W-1:0] w_parent;
  logic              w_seq_full;
  logic              w_cur_root;

  assign w_over     = rd_state[OVER_BIT];
  assign w_parent   = ADDR_W'(rd_state[PAR_MSB:PAR_LSB]);
  assign w_seq_full = &r_seq_ptr;
  assign w_cur_root = (r_cur == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= C_ST_IDLE;
      r_cur      <= '0;
      r_seq_ptr  <= '0;
      r_position <= '0;
      r_i        <= '0;
      r_z        <= '0;
      r_k        <= '0;
      r_l        <= '0;
    end else begin
      case (r_state)
        C_ST_IDLE, C_ST_DONE, C_ST_OVF: begin
          if (start) begin
            r_cur     <= '0;
            r_seq_ptr <= ADDR_W'(1);
            r_state   <= C_ST_READ;
          end
        end
        C_ST_READ: r_state <= C_ST_LATCH;
        C_ST_LATCH: begin
          r_position <= rd_state[POS_MSB:POS_LSB];
          r_i        <= rd_inex[INEX_I_MSB:INEX_I_LSB];
          r_z        <= rd_inex[INEX_Z_MSB:INEX_Z_LSB];
          r_k        <= rd_inex[INEX_K_MSB:INEX_K_LSB];
          r_l        <= rd_inex[INEX_L_MSB:INEX_L_LSB];
          // Completed frames return to their parent; a completed root ends the walk.
          if (w_over) begin
            if (w_cur_root) begin
              r_state <= C_ST_DONE;
            end else begin
              r_cur   <= w_parent;
              r_state <= C_ST_READ;
            end
          end else begin
            r_state <= C_ST_PRESENT;
          end
        end
        C_ST_PRESENT: begin
          if (out_ready) r_state <= C_ST_WB_WAIT;
        end
        C_ST_WB_WAIT: begin
          if (wb_done) begin
            if (!wb_new_call) begin
              r_state <= C_ST_READ;
            end else if (w_seq_full) begin
              r_state <= C_ST_OVF;
            end else begin
              r_cur     <= r_seq_ptr;
              r_seq_ptr <= r_seq_ptr + ADDR_W'(1);
              r_state   <= C_ST_READ;
            end
          end
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

  assign rd_en        = (r_state == C_ST_READ);
  assign rd_addr      = r_cur;
  assign out_valid    = (r_state == C_ST_PRESENT);
  assign out_addr     = r_cur;
  assign out_position = r_position;
  assign out_i        = r_i;
  assign out_z        = r_z;
  assign out_k        = r_k;
  assign out_l        = r_l;
  assign seq_w_addr   = r_seq_ptr;
  assign busy         = (r_state == C_ST_READ)    || (r_state == C_ST_LATCH) ||
                        (r_state == C_ST_PRESENT) || (r_state == C_ST_WB_WAIT);
  assign done         = (r_state == C_ST_DONE);
  assign overflow     = (r_state == C_ST_OVF);

endmodule
`default_nettype wire

// File: tb/tb_call_frame_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_call_frame_fetch                                                      |
// | Randomized bench with a traversal-level reference model of the fetcher.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_call_frame_fetch;

  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  localparam int PH_OFF   = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_PRES  = 2;
  localparam int PH_WAIT  = 3;
  localparam int PH_DONE  = 4;
  localparam int PH_OVF   = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [17:0]   rd_state;
  logic [31:0]   rd_inex;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [4:0]    out_position;
  logic [7:0]    out_i, out_z, out_k, out_l;
  logic          wb_done = 1'b0;
  logic          wb_new_call = 1'b0;
  logic [AW-1:0] seq_w_addr;
  logic          busy, done, overflow;

  always #5 clk = ~clk;

  call_frame_fetch #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_state(rd_state), .rd_inex(rd_inex),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_position(out_position), .out_i(out_i), .out_z(out_z), .out_k(out_k), .out_l(out_l),
    .wb_done(wb_done), .wb_new_call(wb_new_call), .seq_w_addr(seq_w_addr),
    .busy(busy), .done(done), .overflow(overflow)
  );

  // Frame memories with one-cycle synchronous read.
  logic [17:0] state_mem [DEPTH];
  logic [31:0] inex_mem  [DEPTH];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_state <= state_mem[rd_addr];
      rd_inex  <= inex_mem[rd_addr];
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          chk_en  = 0;

  // Reference model: traversal phase, pointers, and the walk of the current fetch.
  int          m_ph  = PH_OFF;
  int          m_cur = 0;
  int          m_seq = 0;
  int          m_launch = 0;
  int          m_ready  = 0;
  bit          m_live   = 0;
  logic [17:0] m_fs;
  logic [31:0] m_fi;
  int          m_path [DEPTH];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Follow over-flagged frames up the parent chain to the frame that will be shown.
  task automatic launch();
    int a;
    int k;
    a = m_cur;
    k = 0;
    m_path[0] = a;
    while (state_mem[a][0] && a != 0 && k < DEPTH - 1) begin
      a = int'(state_mem[a][12:1]);
      k++;
      m_path[k] = a;
    end
    m_launch = cyc;
    m_ready  = cyc + 2 + 2 * k;
    m_live   = !state_mem[a][0];
    m_cur    = a;
    m_fs     = state_mem[a];
    m_fi     = inex_mem[a];
    m_ph     = PH_FETCH;
  endtask

  task automatic advance(input logic rs, input logic s, input logic r, input logic wd, input logic wn);
    if (!rs) begin
      m_ph  = PH_OFF;
      m_cur = 0;
      m_seq = 0;
      return;
    end
    case (m_ph)
      PH_OFF, PH_DONE, PH_OVF: if (s) begin m_cur = 0; m_seq = 1; launch(); end
      PH_PRES: if (r) m_ph = PH_WAIT;
      PH_WAIT: if (wd) begin
        if (!wn) launch();
        else if (m_seq == DEPTH - 1) m_ph = PH_OVF;
        else begin m_cur = m_seq; m_seq++; launch(); end
      end
      default: ;
    endcase
    if (m_ph == PH_FETCH && cyc >= m_ready) m_ph = m_live ? PH_PRES : PH_DONE;
  endtask

  task automatic step(input logic rs, input logic s, input logic r, input logic wd, input logic wn);
    rst_n = rs; start = s; out_ready = r; wb_done = wd; wb_new_call = wn;
    @(posedge clk);
    #1;
    cyc++;
    advance(rs, s, r, wd, wn);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Write-back stand-in: updates the presented frame, optionally pushes a child.
  task automatic wb_random(input int p_new, input int p_over);
    int          f;
    logic [4:0]  pos;
    logic        ov;
    logic        rdy;
    f   = m_cur;
    pos = 5'($urandom);
    ov  = ($urandom_range(0, 99) < p_over);
    rdy = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 99) < p_new) begin
      if (m_seq != DEPTH - 1) begin
        state_mem[m_seq] = {5'($urandom), 12'(f), ov};
        inex_mem[m_seq]  = $urandom;
      end
      state_mem[f] = {pos, state_mem[f][12:1], 1'b0};
      step(1'b1, 1'b0, rdy, 1'b1, 1'b1);
    end else begin
      state_mem[f] = {pos, state_mem[f][12:1], ov};
      step(1'b1, 1'b0, rdy, 1'b1, 1'b0);
    end
  endtask

  task automatic run_random(input int max_cyc, input int p_new, input int p_over);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < max_cyc && m_ph != PH_DONE && m_ph != PH_OVF; c++) begin
      if (m_ph == PH_WAIT && $urandom_range(0, 2) != 0)
        wb_random(p_new, p_over);
      else
        step(1'b1, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
  endtask

  always @(negedge clk) begin
    int off;
    bit e_rd;
    if (chk_en) begin
      off  = cyc - m_launch;
      e_rd = (m_ph == PH_FETCH) && (off % 2 == 0);
      cmp("rd_en", rd_en, e_rd);
      if (e_rd) cmp("rd_addr", rd_addr, m_path[off / 2]);
      cmp("out_valid", out_valid, m_ph == PH_PRES);
      cmp("busy", busy, m_ph == PH_FETCH || m_ph == PH_PRES || m_ph == PH_WAIT);
      cmp("done", done, m_ph == PH_DONE);
      cmp("overflow", overflow, m_ph == PH_OVF);
      cmp("seq_w_addr", seq_w_addr, m_seq);
      if (m_ph == PH_PRES) begin
        cmp("out_addr", out_addr, m_cur);
        cmp("out_position", out_position, m_fs[17:13]);
        cmp("out_izkl", {out_i, out_z, out_k, out_l}, m_fi);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      state_mem[i] = '0;
      inex_mem[i]  = '0;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("reset_ctrl", {out_valid, rd_en, busy, done, overflow}, 5'b0);
    cmp("reset_addr", {rd_addr, out_addr, seq_w_addr}, 36'h0);
    cmp("reset_frame", {out_position, out_i, out_z, out_k, out_l}, 37'h0);

    // Root live, frame 1 completed with parent 0.
    state_mem[0] = 18'h00000;
    inex_mem[0]  = 32'h05030007;
    state_mem[1] = 18'h00001;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("root_read", {rd_en, rd_addr}, {1'b1, 12'h000});
    idle();
    cmp("root_latch_no_valid", out_valid, 1'b0);
    idle();
    cmp("root_valid_cycle3", out_valid, 1'b1);
    cmp("root_frame", {out_addr, out_i, out_z, out_k, out_l}, {12'h000, 32'h05030007});
    repeat (4) idle();
    cmp("root_held", {out_valid, out_i, out_z, out_k, out_l}, {1'b1, 32'h05030007});
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("wait_seq1", {out_valid, seq_w_addr}, {1'b0, 12'h001});
    state_mem[0] = 18'h06000;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cmp("push_read1", {rd_en, rd_addr, seq_w_addr}, {1'b1, 12'h001, 12'h002});
    idle();
    idle();
    cmp("pop_read0", {rd_en, rd_addr}, {1'b1, 12'h000});
    idle();
    idle();
    cmp("root_pos3", {out_valid, out_addr, out_position}, {1'b1, 12'h000, 5'd3});
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    state_mem[0] = 18'h06001;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("refetch_root", {rd_en, rd_addr}, {1'b1, 12'h000});
    idle();
    idle();
    cmp("root_done", {done, busy, out_valid}, 3'b100);

    // Reset while presenting abandons the frame.
    state_mem[0] = 18'h00000;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    cmp("pre_reset_valid", out_valid, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("reset_in_present", {out_valid, busy}, 2'b00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("restart_read0", {rd_en, rd_addr}, {1'b1, 12'h000});

    for (int t = 0; t < 10; t++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      state_mem[0] = {5'($urandom), 12'($urandom), 1'b0};
      inex_mem[0]  = $urandom;
      run_random(3000, 50, 35);
    end

    // Push until the sequential pointer is exhausted.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    state_mem[0] = 18'h00000;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 40000 && m_ph != PH_OVF; c++) begin
      if (m_ph == PH_WAIT) wb_random(100, 0);
      else step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    cmp("overflow_end", {overflow, busy, seq_w_addr}, {1'b1, 1'b0, 12'hFFF});
    repeat (3) idle();
    cmp("overflow_hold", {overflow, seq_w_addr}, {1'b1, 12'hFFF});
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("ovf_restart", {overflow, busy, seq_w_addr}, {1'b0, 1'b1, 12'h001});
    repeat (4) idle();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/call_frame_fetch.md
# call_frame_fetch

Fetch stage of the recursion engine. It reads the current call frame (state word plus InexRecur word) from the frame memories and pops completed frames back to their parent. Live frames are presented to the downstream execute path over a valid/ready handshake. It also owns the sequential push pointer that the write-back stage uses when it creates a new call, and it stalls until write-back commits before fetching again.

## Interface
- `ADDR_W`, 12: frame memory address width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin traversal at root frame, address 0. Ignored unless idle/done.
- `rd_en` out 1: read strobe to state and InexRecur memories.
- `rd_addr` out ADDR_W: read address.
- `rd_state` in 18: state word. Fields: [17:13] position, [12:1] parent address, [0] over flag.
- `rd_inex` in 32: InexRecur word {i, z, k, l}, 8 bits each.
- `out_valid` out 1, `out_ready` in 1: frame handshake to the execute path.
- `out_addr` out ADDR_W: current frame address.
- `out_position` out 5: execution position.
- `out_i`, `out_z`, `out_k`, `out_l` out 8 each: frame parameters.
- `wb_done` in 1: one-cycle pulse when write-back has committed the presented frame.
- `wb_new_call` in 1: qualifies `wb_done`; 1 means a frame was pushed at `seq_w_addr`.
- `seq_w_addr` out ADDR_W: sequential write address for the next pushed frame.
- `busy` out 1: traversal in progress.
- `done` out 1: level; root frame completed.
- `overflow` out 1: level; push attempted with no free address.

## Operation
- FSM states and transitions:
  - IDLE: on `start`, cur←0, seq_ptr←1, clear `done`/`overflow`; go to READ.
  - READ: `rd_en`=1, `rd_addr`=cur; go to LATCH.
  - LATCH: memory data valid this cycle; capture both words into frame registers.
    - If over=1 and cur=0: go to DONE.
    - If over=1 and cur≠0: cur←parent; go to READ.
    - If over=0: go to PRESENT.
  - PRESENT: `out_valid`=1, all `out_*` stable. On `out_valid`&&`out_ready`, go to WB_WAIT.
  - WB_WAIT: wait for `wb_done`.
    - If `wb_new_call`=0: go to READ with cur unchanged, re-fetching the updated position.
    - If `wb_new_call`=1 and seq_ptr=2^ADDR_W−1: go to OVF.
    - If `wb_new_call`=1 otherwise: cur←seq_ptr, seq_ptr←seq_ptr+1; go to READ.
  - DONE: `done`=1, `busy`=0; `start` restarts.
  - OVF: `overflow`=1, `busy`=0; `start` restarts.
- `seq_w_addr` = seq_ptr at all times.
- `busy`=1 in READ, LATCH, PRESENT and WB_WAIT.
- `wb_done` outside WB_WAIT is ignored. `start` while busy is ignored.
- No read is issued between handshake and `wb_done`, so read-after-write on the same address cannot occur.
- Parent address is used verbatim. There is no cycle detection.

## Timing
- Memories are synchronous with 1-cycle read latency. `rd_addr` is sampled at the end of READ, and data is valid during LATCH.
- `start` high in cycle 0 → READ in cycle 1 → LATCH in cycle 2 → `out_valid` in cycle 3.
- Each popped frame costs 2 cycles (READ+LATCH).
- `wb_done` in cycle n → READ in n+1 → `out_valid` in n+3 if the frame is live.
- `out_*` hold constant while `out_valid`=1 and `out_ready`=0. `out_valid` drops the cycle after the handshake.
- Reset values:
  - `out_valid`, `rd_en`, `busy`, `done`, `overflow` = 0.
  - `rd_addr`, `out_addr`, `seq_w_addr` = 0.
  - `out_position`, `out_i`, `out_z`, `out_k`, `out_l` = 0.
  - FSM = IDLE.
- Reset has priority in any state, including mid-PRESENT and mid-WB_WAIT. Outputs take reset values on the next edge, and the pending frame is abandoned.

## Structure
- Shared package holds:
  - State-word field positions: POS_MSB=17, POS_LSB=13, PAR_MSB=12, PAR_LSB=1, OVER_BIT=0.
  - InexRecur field positions.
  - `ADDR_W`.
  - FSM state encoding.
  - The write-back stage uses the same field constants.
- Single module. No sub-module needed.

## Test plan
- Root preloaded with state 0x00000 and inex 0x05030007; `start` in cycle 0 → `out_valid` in cycle 3 with addr 0, i=5, z=3, k=0, l=7. Hold `out_ready`=0 for 4 cycles → outputs stable.
- After the root handshake, `wb_done`+`wb_new_call`=1 → `seq_w_addr` was 1 during WB_WAIT, next `rd_addr`=1, `seq_w_addr` becomes 2.
- Frame 1 has over=1, parent=0 → the READ after the frame 1 read is at addr 0. Root with updated position 3 is presented with `out_position`=3.
- Root state over=1 → `done`=1 and `busy`=0 two cycles after its READ; `out_valid` never rises.
- seq_ptr=4095 and `wb_done`+`wb_new_call` → `overflow`=1, `busy`=0, `seq_w_addr` stays 4095.
- `rst_n`=0 while in PRESENT → next cycle `out_valid`=0, `busy`=0, FSM IDLE. A following `start` re-fetches addr 0.
